// File: rtl/freq_divider_prog.sv
// Programmable divider: up-counter reloads from a left-aligned selector, pulses co at all-ones.
// Optional prescaler on the count tick when PRESCALE_EN is defined.
module freq_divider_prog #(
  parameter int CNT_W = 9,
  parameter int SEL_W = 5,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             ld,
  input  logic             upd,
  input  logic [SEL_W-1:0] parIn,
  input  logic             mode,
`ifdef PRESCALE_EN
  input  logic [PRE_W-1:0] pre_div,
`endif
  output logic             co,
  output logic             sq_out,
  output logic             pend,
  output logic [CNT_W-1:0] count
);

  localparam int LOW_W = CNT_W - SEL_W;

  if (SEL_W > CNT_W || PRE_W < 1) begin : g_bad_param
    $error("freq_divider_prog: SEL_W must not exceed CNT_W and PRE_W must be positive");
  end

  logic [CNT_W-1:0] r_count;
  logic [SEL_W-1:0] r_active;
  logic [SEL_W-1:0] r_shadow;
  logic             r_pend;
  logic             r_sq;
  logic             w_tick;
  logic             w_co;
  logic [SEL_W-1:0] w_reload_sel;
  logic [CNT_W-1:0] w_reload_val;
  logic [CNT_W-1:0] w_load_val;

`ifdef PRESCALE_EN
  logic [PRE_W-1:0] r_pre_cnt;

  assign w_tick = en & (r_pre_cnt == pre_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre_cnt <= '0;
    end else if (ld || w_tick) begin
      r_pre_cnt <= '0;
    end else if (en) begin
      r_pre_cnt <= r_pre_cnt + PRE_W'(1);
    end
  end
`else
  assign w_tick = en;
`endif

  assign w_co = w_tick & (&r_count);

  // A deferred update arriving on the terminal-count cycle is used directly for that reload.
  always_comb begin
    w_reload_sel = r_active;
    if (upd) begin
      w_reload_sel = parIn;
    end else if (r_pend) begin
      w_reload_sel = r_shadow;
    end
  end

  assign w_reload_val = CNT_W'(w_reload_sel) << LOW_W;
  assign w_load_val   = CNT_W'(parIn) << LOW_W;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_active <= '0;
      r_shadow <= '0;
      r_pend   <= 1'b0;
      r_sq     <= 1'b0;
    end else begin
      if (ld) begin
        r_count  <= w_load_val;
        r_active <= parIn;
        r_pend   <= 1'b0;
      end else if (w_co) begin
        r_count  <= w_reload_val;
        r_active <= w_reload_sel;
        r_pend   <= 1'b0;
      end else begin
        if (w_tick) begin
          r_count <= r_count + CNT_W'(1);
        end
        if (upd) begin
          r_shadow <= parIn;
          r_pend   <= 1'b1;
        end
      end
      r_sq <= mode ? (r_sq ^ w_co) : 1'b0;
    end
  end

  assign co     = w_co;
  assign sq_out = r_sq;
  assign pend   = r_pend;
  assign count  = r_count;

endmodule

// File: tb/tb_freq_divider_prog.sv
// Self-checking bench for freq_divider_prog: expected co cycles / sq levels queued, then
// popped as co pulses are observed.
module tb_freq_divider_prog;

  logic       clk;
  logic       reset;
  logic       en;
  logic       ld;
  logic       upd;
  logic [4:0] parIn;
  logic       mode;
`ifdef PRESCALE_EN
  logic [3:0] pre_div;
`endif
  logic       co;
  logic       sq_out;
  logic       pend;
  logic [8:0] count;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   exp_q[$];
  logic exp_sq_q[$];

  freq_divider_prog #(.CNT_W(9), .SEL_W(5), .PRE_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .ld     (ld),
    .upd    (upd),
    .parIn  (parIn),
    .mode   (mode),
`ifdef PRESCALE_EN
    .pre_div(pre_div),
`endif
    .co     (co),
    .sq_out (sq_out),
    .pend   (pend),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic wait_co(input int budget, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (co === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        $display("co at cycle %0d count=%0d pend=%0b sq=%0b", cyc, count, pend, sq_out);
        return;
      end
    end
  endtask

  task automatic test_reset();
    n_total++; if (count !== 9'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_total++; if (pend !== 1'b0) $display("FAIL reset_pend: got %0b want 0", pend); else n_pass++;
    n_total++; if (sq_out !== 1'b0) $display("FAIL reset_sq: got %0b want 0", sq_out); else n_pass++;
    n_total++; if (co !== 1'b0) $display("FAIL reset_co: got %0b want 0", co); else n_pass++;
  endtask

  task automatic test_free_run();
    int c0, at, exp;
    bit ok;
    reset = 1'b0;
    en    = 1'b1;
    c0    = cyc;
    exp_q.push_back(c0 + 511);
    exp_q.push_back(c0 + 1023);
    exp_q.push_back(c0 + 1535);
    repeat (100) @(negedge clk);
    n_total++; if (count !== 9'd100) $display("FAIL free_count100: got %0d want 100", count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      wait_co(600, at, ok);
      exp = exp_q.pop_front();
      n_total++; if (!ok || at != exp) $display("FAIL free_co_cycle: got %0d want %0d", at, exp); else n_pass++;
      @(negedge clk);
      n_total++; if (co !== 1'b0 || count !== 9'd0)
        $display("FAIL free_co_width: co=%0b count=%0d want co=0 count=0", co, count); else n_pass++;
    end
  endtask

  task automatic test_load();
    int c, at, exp;
    bit ok;
    ld    = 1'b1;
    parIn = 5'd30;
    c     = cyc;
    exp_q.push_back(c + 32);
    exp_q.push_back(c + 64);
    exp_q.push_back(c + 96);
    @(negedge clk);
    ld = 1'b0;
    n_total++; if (count !== 9'd480) $display("FAIL load_count: got %0d want 480", count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      wait_co(100, at, ok);
      exp = exp_q.pop_front();
      n_total++; if (!ok || at != exp) $display("FAIL load_co_cycle: got %0d want %0d", at, exp); else n_pass++;
    end
  endtask

  task automatic test_deferred();
    int t, at, exp;
    bit ok;
    t = cyc;
    repeat (10) @(negedge clk);
    upd   = 1'b1;
    parIn = 5'd28;
    exp_q.push_back(t + 32);
    exp_q.push_back(t + 96);
    exp_q.push_back(t + 160);
    @(negedge clk);
    upd = 1'b0;
    n_total++; if (pend !== 1'b1) $display("FAIL defer_pend_set: got %0b want 1", pend); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      wait_co(200, at, ok);
      exp = exp_q.pop_front();
      n_total++; if (!ok || at != exp) $display("FAIL defer_co_cycle: got %0d want %0d", at, exp); else n_pass++;
      if (i == 0) begin
        @(negedge clk);
        n_total++; if (pend !== 1'b0 || count !== 9'd448)
          $display("FAIL defer_apply: pend=%0b count=%0d want pend=0 count=448", pend, count); else n_pass++;
      end
    end
  endtask

  task automatic test_upd_on_co();
    int x, at, exp;
    bit ok;
    x     = cyc;
    upd   = 1'b1;
    parIn = 5'd30;
    exp_q.push_back(x + 32);
    exp_q.push_back(x + 64);
    @(negedge clk);
    upd = 1'b0;
    n_total++; if (pend !== 1'b0 || count !== 9'd480)
      $display("FAIL bypass_reload: pend=%0b count=%0d want pend=0 count=480", pend, count); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      wait_co(100, at, ok);
      exp = exp_q.pop_front();
      n_total++; if (!ok || at != exp || pend !== 1'b0)
        $display("FAIL bypass_co_cycle: got %0d pend=%0b want %0d pend=0", at, pend, exp); else n_pass++;
    end
  endtask

  task automatic test_enable_hold();
    int y, at, exp;
    bit ok;
    bit co_seen;
    y = cyc;
    repeat (21) @(negedge clk);
    n_total++; if (count !== 9'd500) $display("FAIL hold_pre_count: got %0d want 500", count); else n_pass++;
    en      = 1'b0;
    co_seen = 1'b0;
    exp_q.push_back(y + 42);
    repeat (10) begin
      @(negedge clk);
      if (co !== 1'b0) co_seen = 1'b1;
    end
    n_total++; if (count !== 9'd500 || co_seen)
      $display("FAIL hold_count: count=%0d co_seen=%0b want count=500 co_seen=0", count, co_seen); else n_pass++;
    en = 1'b1;
    wait_co(100, at, ok);
    exp = exp_q.pop_front();
    n_total++; if (!ok || at != exp) $display("FAIL hold_co_cycle: got %0d want %0d", at, exp); else n_pass++;
  endtask

  task automatic test_square();
    int z, at, exp;
    bit ok;
    logic exp_sq;
    @(negedge clk);
    ld    = 1'b1;
    parIn = 5'd31;
    mode  = 1'b1;
    z     = cyc;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(z + 16 * k);
      exp_sq_q.push_back(k[0]);
    end
    @(negedge clk);
    ld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_co(40, at, ok);
      exp = exp_q.pop_front();
      n_total++; if (!ok || at != exp) $display("FAIL sq_co_cycle: got %0d want %0d", at, exp); else n_pass++;
      @(negedge clk);
      exp_sq = exp_sq_q.pop_front();
      n_total++; if (sq_out !== exp_sq) $display("FAIL sq_toggle: got %0b want %0b", sq_out, exp_sq); else n_pass++;
    end
    mode = 1'b0;
    @(negedge clk);
    n_total++; if (sq_out !== 1'b0) $display("FAIL sq_mode_off: got %0b want 0", sq_out); else n_pass++;
  endtask

  task automatic test_async_reset();
    int c, at, exp;
    bit ok;
    mode = 1'b1;
    wait_co(40, at, ok);
    n_total++; if (!ok) $display("FAIL areset_wait_co: got no co want co within 40 clocks"); else n_pass++;
    @(negedge clk);
    n_total++; if (sq_out !== 1'b1) $display("FAIL areset_sq_pre: got %0b want 1", sq_out); else n_pass++;
    upd   = 1'b1;
    parIn = 5'd5;
    @(negedge clk);
    upd = 1'b0;
    n_total++; if (pend !== 1'b1) $display("FAIL areset_pend_pre: got %0b want 1", pend); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++; if (count !== 9'd0 || pend !== 1'b0 || sq_out !== 1'b0 || co !== 1'b0)
      $display("FAIL areset_async: count=%0d pend=%0b sq=%0b co=%0b want all 0", count, pend, sq_out, co); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    mode  = 1'b0;
    c     = cyc;
    exp_q.push_back(c + 511);
    wait_co(600, at, ok);
    exp = exp_q.pop_front();
    n_total++; if (!ok || at != exp) $display("FAIL areset_co_cycle: got %0d want %0d", at, exp); else n_pass++;
    @(negedge clk);
    n_total++; if (count !== 9'd0 || pend !== 1'b0)
      $display("FAIL areset_discard: count=%0d pend=%0b want count=0 pend=0", count, pend); else n_pass++;
  endtask

`ifdef PRESCALE_EN
  task automatic test_prescale();
    int l, at, exp;
    bit ok;
    pre_div = 4'd3;
    ld      = 1'b1;
    parIn   = 5'd31;
    l       = cyc + 1;
    exp_q.push_back(l + 63);
    exp_q.push_back(l + 127);
    @(negedge clk);
    ld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_co(200, at, ok);
      exp = exp_q.pop_front();
      n_total++; if (!ok || at != exp) $display("FAIL pre_co_cycle: got %0d want %0d", at, exp); else n_pass++;
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    ld    = 1'b0;
    upd   = 1'b0;
    parIn = 5'd0;
    mode  = 1'b0;
`ifdef PRESCALE_EN
    pre_div = 4'd0;
`endif
    repeat (3) @(negedge clk);
    test_reset();
    test_free_run();
    test_load();
    test_deferred();
    test_upd_on_co();
    test_enable_hold();
    test_square();
    test_async_reset();
`ifdef PRESCALE_EN
    test_prescale();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
